// File: rtl/plx_lbus_master.sv
// plx_lbus_master: PLX-style local bus master.
// Runs single or burst (1..8 word) reads and writes through an
// IDLE -> ADDR -> DATA -> TURN sequence, honours target wait states (nREADY)
// and burst terminate (nBTERM). A terminated burst resumes with a fresh
// address phase at the next word address.
// Optional watchdog: define PLX_MASTER_TIMEOUT_EN to abort a DATA phase that
// has waited 255 consecutive cycles on nREADY; undefined, the master waits
// forever and timeout_o is tied low.
module plx_lbus_master (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_i,
  input  logic        wr_i,
  input  logic        cs_sel_i,
  input  logic [5:0]  addr_i,
  input  logic [2:0]  len_i,
  input  logic [31:0] wdat_i,
  output logic        wdat_rd_o,
  output logic [31:0] rdat_o,
  output logic        rdat_vld_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic        nADS,
  output logic        WnR,
  output logic        nRD,
  output logic        nCS2,
  output logic        nCS3,
  output logic [5:0]  LA,
  output logic [31:0] LD_o,
  input  logic [31:0] LD_i,
  output logic        LD_oe_o,
  input  logic        nREADY,
  input  logic        nBTERM
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, TURN} state_t;

  state_t     state;
  logic       wr_q;
  logic       cs_q;
  logic       rearb_q;
  logic [2:0] cnt_q;

  logic xfer;
  logic last_xfer;
  logic bterm_xfer;
  logic wdog_exp;
  logic go_turn;

`ifdef PLX_MASTER_TIMEOUT_EN
  logic [7:0] wdog_q;
`endif

  // Decode this cycle's DATA-phase events: a word moves, the burst ends, the
  // target cuts the burst short, or the watchdog gives up.
  always_comb begin
    xfer       = (state == DATA) && !nREADY;
    last_xfer  = xfer && (cnt_q == 3'd0);
    bterm_xfer = xfer && (cnt_q != 3'd0) && !nBTERM;
`ifdef PLX_MASTER_TIMEOUT_EN
    wdog_exp   = (state == DATA) && nREADY && (wdog_q == 8'd254);
`else
    wdog_exp   = 1'b0;
`endif
    go_turn    = last_xfer || bterm_xfer || wdog_exp;
  end

  // Write data and its consume strobe follow the target's nREADY in the same
  // cycle, so these two stay combinational.
  assign wdat_rd_o = xfer && wr_q;
  assign LD_o      = ((state == DATA) && wr_q) ? wdat_i : 32'h0;

`ifdef PLX_MASTER_TIMEOUT_EN
  // Watchdog counts consecutive stalled DATA cycles; any transfer or a fresh
  // entry into DATA starts it over.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wdog_q <= 8'd0;
    end else if (state == ADDR || xfer) begin
      wdog_q <= 8'd0;
    end else if (state == DATA) begin
      wdog_q <= wdog_q + 8'd1;
    end
  end
`else
  assign timeout_o = 1'b0;
`endif

  // Bus sequencer: state plus every registered bus/status output, each set
  // for the state being entered.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      wr_q       <= 1'b0;
      cs_q       <= 1'b0;
      rearb_q    <= 1'b0;
      cnt_q      <= 3'd0;
      rdat_o     <= 32'h0;
      rdat_vld_o <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
`ifdef PLX_MASTER_TIMEOUT_EN
      timeout_o  <= 1'b0;
`endif
      nADS       <= 1'b1;
      WnR        <= 1'b0;
      nRD        <= 1'b1;
      nCS2       <= 1'b1;
      nCS3       <= 1'b1;
      LA         <= 6'd0;
      LD_oe_o    <= 1'b0;
    end else begin
      done_o     <= 1'b0;
      rdat_vld_o <= 1'b0;
`ifdef PLX_MASTER_TIMEOUT_EN
      timeout_o  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req_i) begin
            wr_q   <= wr_i;
            cs_q   <= cs_sel_i;
            cnt_q  <= len_i;
            LA     <= addr_i;
            busy_o <= 1'b1;
            nADS   <= 1'b0;
            nCS2   <= cs_sel_i;
            nCS3   <= !cs_sel_i;
            WnR    <= wr_i;
            state  <= ADDR;
          end
        end
        ADDR: begin
          nADS    <= 1'b1;
          nRD     <= wr_q;
          LD_oe_o <= wr_q;
          state   <= DATA;
        end
        DATA: begin
          if (xfer) begin
            LA    <= LA + 6'd1;
            cnt_q <= cnt_q - 3'd1;
            if (!wr_q) begin
              rdat_o     <= LD_i;
              rdat_vld_o <= 1'b1;
            end
          end
          if (go_turn) begin
            nCS2    <= 1'b1;
            nCS3    <= 1'b1;
            nRD     <= 1'b1;
            LD_oe_o <= 1'b0;
            WnR     <= 1'b0;
            done_o  <= last_xfer;
            rearb_q <= bterm_xfer;
`ifdef PLX_MASTER_TIMEOUT_EN
            timeout_o <= wdog_exp;
`endif
            state   <= TURN;
          end
        end
        TURN: begin
          if (rearb_q) begin
            nADS  <= 1'b0;
            nCS2  <= cs_q;
            nCS3  <= !cs_q;
            WnR   <= wr_q;
            state <= ADDR;
          end else begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plx_lbus_master.sv
// tb_plx_lbus_master: builds, per transaction, the full expected cycle trace
// from the bus rules (address phase, wait states, word transfers, burst
// terminate, turnaround) and checks the master against it every cycle.
module tb_plx_lbus_master;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        req_i, wr_i, cs_sel_i;
  logic [5:0]  addr_i;
  logic [2:0]  len_i;
  logic [31:0] wdat_i;
  logic        wdat_rd_o;
  logic [31:0] rdat_o;
  logic        rdat_vld_o, busy_o, done_o, timeout_o;
  logic        nADS, WnR, nRD, nCS2, nCS3;
  logic [5:0]  LA;
  logic [31:0] LD_o, LD_i;
  logic        LD_oe_o, nREADY, nBTERM;

  int vectors = 0;
  int miscompares = 0;
  int cyc_no = 0;

  typedef struct {
    logic        req, wr_in, cs_in;
    logic [5:0]  addr_in;
    logic [2:0]  len_in;
    logic        nready, nbterm;
    logic [31:0] ld_in, wdat;
    logic        busy, done, tmo, nads, ncs2, ncs3, wnr, nrd, ld_oe, wdat_rd, rvld;
    logic [5:0]  la;
    logic [31:0] ld_out, rdat;
    bit          chk_bus;
  } cyc_t;

  cyc_t        tr[$];
  int          st[8];
  logic [31:0] dw[8];
  logic [31:0] last_rd = 32'h0;

  always #5 clk_i = ~clk_i;

  plx_lbus_master dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .wr_i(wr_i),
    .cs_sel_i(cs_sel_i), .addr_i(addr_i), .len_i(len_i), .wdat_i(wdat_i),
    .wdat_rd_o(wdat_rd_o), .rdat_o(rdat_o), .rdat_vld_o(rdat_vld_o),
    .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
    .nADS(nADS), .WnR(WnR), .nRD(nRD), .nCS2(nCS2), .nCS3(nCS3), .LA(LA),
    .LD_o(LD_o), .LD_i(LD_i), .LD_oe_o(LD_oe_o), .nREADY(nREADY), .nBTERM(nBTERM)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("[TB] FAIL %s (cycle %0d): got %h, expected %h", name, cyc_no, act, exp);
    end
  endtask

  function automatic cyc_t idle_cyc();
    cyc_t c;
    c.req = 0; c.wr_in = 0; c.cs_in = 0; c.addr_in = 6'h0; c.len_in = 3'd0;
    c.nready = 1; c.nbterm = 1; c.ld_in = 32'h1234_5678; c.wdat = 32'hA5A5_A5A5;
    c.busy = 0; c.done = 0; c.tmo = 0; c.nads = 1; c.ncs2 = 1; c.ncs3 = 1;
    c.wnr = 0; c.nrd = 1; c.ld_oe = 0; c.wdat_rd = 0; c.rvld = 0; c.la = 6'h0;
    c.ld_out = 32'h0; c.rdat = 32'h0; c.chk_bus = 0;
    return c;
  endfunction

  // A cycle with the chip selected in the data phase; ADDR tweaks it.
  function automatic cyc_t bus_cyc(input bit wr, input bit cs, input logic [5:0] la, input bit spam);
    cyc_t c;
    c = idle_cyc();
    c.busy = 1; c.ncs2 = cs; c.ncs3 = !cs; c.la = la; c.wnr = wr;
    c.nrd = wr; c.ld_oe = wr; c.chk_bus = 1;
    if (spam) begin
      c.req = 1; c.wr_in = !wr; c.cs_in = !cs; c.addr_in = 6'h2A; c.len_in = 3'd5;
    end
    return c;
  endfunction

  // Expected trace of one transaction from its parameters, st[] (stall cycles
  // before each word) and dw[] (word data), ending with one IDLE cycle.
  task automatic build(input bit wr, input bit cs, input logic [5:0] addr,
                       input int nwords, input int bterm_word, input bit spam);
    cyc_t        c;
    logic [5:0]  cur;
    bit          prev_rd, fin, seg_end;
    int          w;
    logic [31:0] rd_hold;
    tr.delete();
    cur = addr; prev_rd = 0; w = 0; fin = 0; rd_hold = last_rd;
    c = idle_cyc();
    c.req = 1; c.wr_in = wr; c.cs_in = cs; c.addr_in = addr; c.len_in = 3'(nwords - 1);
    tr.push_back(c);
    while (!fin) begin
      c = bus_cyc(wr, cs, cur, spam);
      c.nads = 0; c.nrd = 1; c.ld_oe = 0;
      tr.push_back(c);
      seg_end = 0;
      while (!seg_end && !fin) begin
        for (int s = 0; s < st[w]; s++) begin
`ifdef PLX_MASTER_TIMEOUT_EN
          if (s == 255) begin
            c = idle_cyc(); c.busy = 1; c.tmo = 1; c.rdat = rd_hold;
            tr.push_back(c);
            tr.push_back(idle_cyc());
            fin = 1;
            break;
          end
`endif
          c = bus_cyc(wr, cs, cur, spam);
          c.nready = 1; c.nbterm = (s == 0) ? 1'b0 : 1'b1;
          c.wdat = dw[w]; c.ld_in = 32'hBAD0_0000 + 32'(s);
          c.ld_out = wr ? dw[w] : 32'h0;
          c.rvld = prev_rd; c.rdat = rd_hold; prev_rd = 0;
          tr.push_back(c);
        end
        if (fin) break;
        c = bus_cyc(wr, cs, cur, spam);
        c.nready = 0; c.nbterm = (w == bterm_word) ? 1'b0 : 1'b1;
        c.wdat = dw[w]; c.ld_in = dw[w]; c.ld_out = wr ? dw[w] : 32'h0;
        c.wdat_rd = wr; c.rvld = prev_rd; c.rdat = rd_hold;
        tr.push_back(c);
        if (!wr) rd_hold = dw[w];
        prev_rd = !wr;
        cur = cur + 6'd1;
        w++;
        if (w == nwords || (w - 1) == bterm_word) begin
          c = idle_cyc(); c.busy = 1; c.done = (w == nwords);
          c.rvld = prev_rd; c.rdat = rd_hold;
          if (spam) c.req = 1;
          tr.push_back(c);
          prev_rd = 0;
          if (w == nwords) begin
            tr.push_back(idle_cyc());
            fin = 1;
          end
          seg_end = 1;
        end
      end
    end
    last_rd = rd_hold;
  endtask

  task automatic checkOutput(input cyc_t c);
    chk("busy_o", busy_o, c.busy);
    chk("done_o", done_o, c.done);
    chk("timeout_o", timeout_o, c.tmo);
    chk("nADS", nADS, c.nads);
    chk("nCS2", nCS2, c.ncs2);
    chk("nCS3", nCS3, c.ncs3);
    chk("nRD", nRD, c.nrd);
    chk("LD_oe_o", LD_oe_o, c.ld_oe);
    chk("wdat_rd_o", wdat_rd_o, c.wdat_rd);
    chk("rdat_vld_o", rdat_vld_o, c.rvld);
    chk("LD_o", LD_o, c.ld_out);
    if (c.chk_bus) begin
      chk("LA", 32'(LA), 32'(c.la));
      chk("WnR", WnR, c.wnr);
    end
    if (c.rvld) chk("rdat_o", rdat_o, c.rdat);
  endtask

  task automatic applyStimulus(input cyc_t c);
    @(negedge clk_i);
    req_i = c.req; wr_i = c.wr_in; cs_sel_i = c.cs_in; addr_i = c.addr_in; len_i = c.len_in;
    nREADY = c.nready; nBTERM = c.nbterm; LD_i = c.ld_in; wdat_i = c.wdat;
    #1;
    checkOutput(c);
    cyc_no++;
  endtask

  task automatic runTrace(input int upto);
    for (int i = 0; i < tr.size() && i < upto; i++) applyStimulus(tr[i]);
  endtask

  task automatic checkReset(input string tag);
    chk({tag, "_nADS"}, nADS, 1'b1);
    chk({tag, "_nRD"}, nRD, 1'b1);
    chk({tag, "_nCS2"}, nCS2, 1'b1);
    chk({tag, "_nCS3"}, nCS3, 1'b1);
    chk({tag, "_WnR"}, WnR, 1'b0);
    chk({tag, "_LA"}, 32'(LA), 32'h0);
    chk({tag, "_LD_o"}, LD_o, 32'h0);
    chk({tag, "_LD_oe"}, LD_oe_o, 1'b0);
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_done"}, done_o, 1'b0);
    chk({tag, "_rvld"}, rdat_vld_o, 1'b0);
    chk({tag, "_wdat_rd"}, wdat_rd_o, 1'b0);
    chk({tag, "_timeout"}, timeout_o, 1'b0);
    chk({tag, "_rdat"}, rdat_o, 32'h0);
  endtask

  function automatic int idxOfDone();
    foreach (tr[i]) if (tr[i].done) return i;
    return -1;
  endfunction

  function automatic int countDone();
    int n = 0;
    foreach (tr[i]) if (tr[i].done) n++;
    return n;
  endfunction

  function automatic int countRvld();
    int n = 0;
    foreach (tr[i]) if (tr[i].rvld) n++;
    return n;
  endfunction

  task automatic clearCfg();
    for (int i = 0; i < 8; i++) begin
      st[i] = 0;
      dw[i] = 32'h0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_time_limit: got running, expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    logic [5:0] la_seq[8];
    logic [5:0] la_got;
    int k;
    rst_n_i = 1'b0; req_i = 0; wr_i = 0; cs_sel_i = 0; addr_i = 6'h0; len_i = 3'd0;
    wdat_i = 32'hA5A5_A5A5; LD_i = 32'h1234_5678; nREADY = 1; nBTERM = 1;
    repeat (3) @(negedge clk_i);
    #1 checkReset("por");
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Single read at 0x05 on nCS2.
    clearCfg();
    dw[0] = 32'hDEAD_BEEF;
    build(1'b0, 1'b0, 6'h05, 1, -1, 1'b0);
    chk("pin_single_done_idx", 32'(idxOfDone()), 32'd3);
    chk("pin_single_rdat", tr[3].rdat, 32'hDEAD_BEEF);
    runTrace(tr.size());

    // Eight-word write on nCS3 wrapping past 0x3F.
    clearCfg();
    for (int i = 0; i < 8; i++) dw[i] = 32'hC0DE_0000 + 32'(i) * 32'h0011_0001;
    build(1'b1, 1'b1, 6'h3E, 8, -1, 1'b0);
    chk("pin_burst_done_idx", 32'(idxOfDone()), 32'd10);
    la_seq = '{6'h3E, 6'h3F, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05};
    k = 0;
    foreach (tr[i]) if (tr[i].wdat_rd && k < 8) begin
      la_got = tr[i].la;
      chk("pin_burst_la", 32'(la_got), 32'(la_seq[k]));
      k++;
    end
    runTrace(tr.size());

    // Two-word read with three wait states per word, busy-time req spam.
    clearCfg();
    st[0] = 3; st[1] = 3;
    dw[0] = 32'h7000_0001; dw[1] = 32'h7000_0002;
    build(1'b0, 1'b0, 6'h0A, 2, -1, 1'b1);
    chk("pin_wait_done_idx", 32'(idxOfDone()), 32'd10);
    chk("pin_wait_rvld_cnt", 32'(countRvld()), 32'd2);
    runTrace(tr.size());

    // Four-word read cut short by nBTERM on the second word.
    clearCfg();
    for (int i = 0; i < 4; i++) dw[i] = 32'h4B00_0000 + 32'(i);
    build(1'b0, 1'b1, 6'h10, 4, 1, 1'b0);
    chk("pin_bterm_done_cnt", 32'(countDone()), 32'd1);
    k = 0;
    foreach (tr[i]) if (tr[i].chk_bus && !tr[i].nads) begin
      if (k == 1) chk("pin_bterm_readdr", 32'(tr[i].la), 32'h12);
      k++;
    end
    chk("pin_bterm_addr_phases", 32'(k), 32'd2);
    runTrace(tr.size());

    // Three-word write on nCS2 with uneven wait states and req spam.
    clearCfg();
    st[0] = 2; st[2] = 1;
    dw[0] = 32'h1111_0000; dw[1] = 32'h2222_0000; dw[2] = 32'h3333_0000;
    build(1'b1, 1'b0, 6'h20, 3, -1, 1'b1);
    runTrace(tr.size());

    // Target never ready on a single write.
    clearCfg();
    st[0] = 1000; dw[0] = 32'h0F0F_0F0F;
    build(1'b1, 1'b1, 6'h01, 1, -1, 1'b0);
`ifdef PLX_MASTER_TIMEOUT_EN
    chk("pin_tmo_idx", 32'(tr.size()), 32'd259);
    chk("pin_tmo_no_done", 32'(countDone()), 32'd0);
`else
    chk("pin_hang_len", 32'(tr.size()), 32'd1005);
`endif
    runTrace(tr.size());

    // Reset during the data phase of an eight-word read.
    clearCfg();
    for (int i = 0; i < 8; i++) dw[i] = 32'h9900_0000 + 32'(i);
    build(1'b0, 1'b0, 6'h30, 8, -1, 1'b0);
    runTrace(4);
    @(negedge clk_i);
    rst_n_i = 1'b0;
    #1 checkReset("midrst");
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1; req_i = 0; nREADY = 1; nBTERM = 1;
    last_rd = 32'h0;
    clearCfg();
    dw[0] = 32'h0BAD_F00D;
    build(1'b0, 1'b1, 6'h07, 1, -1, 1'b0);
    runTrace(tr.size());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
